peripheral_spi_master: RTL and testbench

Memory-mapped 8-bit SPI master peripheral for the j1 SoC bus.
- The CPU writes a transmit byte and pulses a start bit.
- The block shifts the byte out on mosi while capturing miso.
- It flags completion in a status register; software then reads the received byte.
- It sits between the SoC peripheral bus (cs/rd/wr/addr/d_in/d_out) and external SPI pins.

---
 rtl/peripheral_spi_master_pkg.sv | 16 +
 rtl/peripheral_spi_master_if.sv | 16 +
 rtl/peripheral_spi_master_core.sv | 114 +++++++++++
 rtl/peripheral_spi_master.sv | 85 ++++++++
 tb/tb_peripheral_spi_master.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/peripheral_spi_master_pkg.sv
// Shared definitions for the SPI master peripheral: bus register map and
// engine state encoding.
package peripheral_spi_master_pkg;

   typedef logic [3:0] reg_addr_t;

   localparam reg_addr_t ADDR_TX     = 4'h0;
   localparam reg_addr_t ADDR_START  = 4'h2;
   localparam reg_addr_t ADDR_SRST   = 4'h4;
   localparam reg_addr_t ADDR_RX     = 4'h6;
   localparam reg_addr_t ADDR_STATUS = 4'hA;

   localparam logic [0:0] ST_IDLE     = 1'b0;
   localparam logic [0:0] ST_TRANSFER = 1'b1;

endpackage

// File: rtl/peripheral_spi_master_if.sv
// SoC peripheral bus as seen by the SPI master: the CPU side drives the
// strobes, the peripheral returns combinational read data.
interface peripheral_spi_master_if;
   import peripheral_spi_master_pkg::*;

   logic        cs;
   logic        rd;
   logic        wr;
   reg_addr_t   addr;
   logic [15:0] d_in;
   logic [15:0] d_out;

   modport master (output cs, rd, wr, addr, d_in, input d_out);
   modport slave  (input cs, rd, wr, addr, d_in, output d_out);

endinterface

// File: rtl/peripheral_spi_master_core.sv
// SPI mode-0 shift engine: clock divider, IDLE/TRANSFER FSM, MSB-first
// transmit shifter and receive shifter.
module spi_master_core
   import peripheral_spi_master_pkg::*;
#(
   parameter int CLK_DIV = 4,
   parameter int DATA_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              start,
   input  logic              soft_rst,
   input  logic              miso,
   output logic [DATA_W-1:0] rx_data,
   output logic              busy,
   output logic              done,
   output logic              mosi,
   output logic              ss,
   output logic              sck
);

   localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

   logic [0:0]        state_reg;
   logic [CNT_W-1:0]  cnt_reg;
   logic [BIT_W-1:0]  bit_reg;
   logic [DATA_W-1:0] tx_shift_reg;
   logic [DATA_W-1:0] rx_shift_reg;
   logic [DATA_W-1:0] rx_data_reg;
   logic              busy_reg;
   logic              done_reg;
   logic              mosi_reg;
   logic              ss_reg;
   logic              sck_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg    <= ST_IDLE;
         cnt_reg      <= '0;
         bit_reg      <= '0;
         tx_shift_reg <= '0;
         rx_shift_reg <= '0;
         rx_data_reg  <= '0;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
         mosi_reg     <= 1'b0;
         ss_reg       <= 1'b1;
         sck_reg      <= 1'b0;
      end else if (soft_rst) begin
         // Received byte survives a soft reset; everything else restarts.
         state_reg    <= ST_IDLE;
         cnt_reg      <= '0;
         bit_reg      <= '0;
         tx_shift_reg <= '0;
         rx_shift_reg <= '0;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
         mosi_reg     <= 1'b0;
         ss_reg       <= 1'b1;
         sck_reg      <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (start) begin
                  state_reg    <= ST_TRANSFER;
                  cnt_reg      <= '0;
                  bit_reg      <= '0;
                  tx_shift_reg <= tx_data;
                  mosi_reg     <= tx_data[DATA_W-1];
                  ss_reg       <= 1'b0;
                  sck_reg      <= 1'b0;
                  busy_reg     <= 1'b1;
                  done_reg     <= 1'b0;
               end
            end
            ST_TRANSFER: begin
               if (cnt_reg == CNT_LAST) begin
                  cnt_reg <= '0;
                  sck_reg <= ~sck_reg;
                  if (!sck_reg) begin
                     rx_shift_reg <= {rx_shift_reg[DATA_W-2:0], miso};
                  end else if (bit_reg == BIT_LAST) begin
                     // Last falling edge closes the frame; mosi keeps its bit.
                     state_reg   <= ST_IDLE;
                     rx_data_reg <= rx_shift_reg;
                     busy_reg    <= 1'b0;
                     done_reg    <= 1'b1;
                     ss_reg      <= 1'b1;
                  end else begin
                     bit_reg      <= bit_reg + 1'b1;
                     tx_shift_reg <= {tx_shift_reg[DATA_W-2:0], 1'b0};
                     mosi_reg     <= tx_shift_reg[DATA_W-2];
                  end
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign rx_data = rx_data_reg;
   assign busy    = busy_reg;
   assign done    = done_reg;
   assign mosi    = mosi_reg;
   assign ss      = ss_reg;
   assign sck     = sck_reg;

endmodule

// File: rtl/peripheral_spi_master.sv
// Memory-mapped SPI master: bus decode, control registers and read mux in
// front of the shift engine.
module peripheral_spi_master
   import peripheral_spi_master_pkg::*;
#(
   parameter int CLK_DIV = 4,
   parameter int DATA_W  = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   peripheral_spi_master_if.slave   bus,
   input  logic                     miso,
   output logic                     mosi,
   output logic                     ss,
   output logic                     sck
);

   logic [DATA_W-1:0] tx_data_reg;
   logic              start_q_reg;
   logic              start_prev_reg;
   logic              srst_reg;
   logic              srst_next;
   logic              wr_en;
   logic              start_pulse;
   logic [DATA_W-1:0] rx_data;
   logic              busy;
   logic              done;
   logic              unused_bits;

   assign wr_en       = bus.cs & bus.wr;
   assign start_pulse = start_q_reg & ~start_prev_reg;
   assign unused_bits = ^bus.d_in[15:DATA_W];

   // The engine sees the soft-reset value being written, so an abort takes
   // effect on the same edge as the register write and beats a start edge.
   always_comb begin
      srst_next = srst_reg;
      if (wr_en && bus.addr == ADDR_SRST) srst_next = bus.d_in[0];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_data_reg    <= '0;
         start_q_reg    <= 1'b0;
         start_prev_reg <= 1'b0;
         srst_reg       <= 1'b0;
      end else begin
         start_prev_reg <= start_q_reg;
         srst_reg       <= srst_next;
         if (wr_en && bus.addr == ADDR_TX)    tx_data_reg <= bus.d_in[DATA_W-1:0];
         if (wr_en && bus.addr == ADDR_START) start_q_reg <= bus.d_in[0];
      end
   end

   spi_master_core #(
      .CLK_DIV (CLK_DIV),
      .DATA_W  (DATA_W)
   ) u_core (
      .clk      (clk),
      .rst      (rst),
      .tx_data  (tx_data_reg),
      .start    (start_pulse),
      .soft_rst (srst_next),
      .miso     (miso),
      .rx_data  (rx_data),
      .busy     (busy),
      .done     (done),
      .mosi     (mosi),
      .ss       (ss),
      .sck      (sck)
   );

   always_comb begin
      bus.d_out = '0;
      if (bus.cs && bus.rd) begin
         case (bus.addr)
            ADDR_RX:     bus.d_out = 16'(rx_data);
            ADDR_STATUS: bus.d_out = {14'h0, busy, done};
            ADDR_TX:     bus.d_out = 16'(tx_data_reg);
            default:     bus.d_out = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_peripheral_spi_master.sv
// Directed bench for the SPI master: bus accesses, frame timing, MSB-first
// transmit, receive, soft-reset abort, start-while-busy and bus gating.
module tb_peripheral_spi_master;
   import peripheral_spi_master_pkg::*;

   logic clk;
   logic rst;
   logic miso;
   logic mosi;
   logic ss;
   logic sck;

   int vectors;
   int miscompares;

   peripheral_spi_master_if bus_if ();

   peripheral_spi_master #(
      .CLK_DIV (4),
      .DATA_W  (8)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus_if),
      .miso (miso),
      .mosi (mosi),
      .ss   (ss),
      .sck  (sck)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SPI slave-side monitor, sampled on the falling clk edge.
   logic       sck_prev;
   logic       ss_prev;
   int         rise_cnt;
   int         ss_low;
   int         last_frame_len;
   int         frames_done;
   logic [7:0] mosi_cap;
   logic [7:0] miso_pat;

   initial begin
      sck_prev = 1'b0;
      ss_prev = 1'b1;
      rise_cnt = 0;
      ss_low = 0;
      last_frame_len = 0;
      frames_done = 0;
      mosi_cap = 8'h00;
      miso_pat = 8'h00;
      miso = 1'b0;
   end

   always @(negedge clk) begin
      if (ss_prev && !ss) begin
         rise_cnt = 0;
         ss_low = 0;
         mosi_cap = 8'h00;
      end
      if (!ss) ss_low = ss_low + 1;
      if (!ss_prev && ss) begin
         last_frame_len = ss_low;
         frames_done = frames_done + 1;
      end
      if (sck && !sck_prev) begin
         mosi_cap = {mosi_cap[6:0], mosi};
         rise_cnt = rise_cnt + 1;
      end
      if (rise_cnt < 8) miso = miso_pat[7 - rise_cnt];
      sck_prev = sck;
      ss_prev = ss;
   end

   task automatic bus_write(input logic [3:0] a, input logic [15:0] d);
      @(negedge clk);
      bus_if.cs = 1'b1; bus_if.wr = 1'b1; bus_if.addr = a; bus_if.d_in = d;
      @(negedge clk);
      bus_if.cs = 1'b0; bus_if.wr = 1'b0;
      $display("wr addr=%h data=%h", a, d);
   endtask

   task automatic bus_read(input logic [3:0] a, output logic [15:0] d);
      @(negedge clk);
      bus_if.cs = 1'b1; bus_if.rd = 1'b1; bus_if.addr = a;
      #1 d = bus_if.d_out;
      bus_if.cs = 1'b0; bus_if.rd = 1'b0;
      $display("rd addr=%h data=%h", a, d);
   endtask

   task automatic launch(input logic [7:0] tx);
      bus_write(ADDR_TX, {8'h00, tx});
      bus_write(ADDR_START, 16'h0001);
      bus_write(ADDR_START, 16'h0000);
   endtask

   task automatic wait_frame(input int base, input string tag);
      int n;
      n = 0;
      while (frames_done == base && n < 300) begin
         @(negedge clk);
         n++;
      end
      vectors++;
      if (frames_done == base) begin
         miscompares++;
         $display("FAIL %s_timeout: frame end not seen after %0d cycles, required within 300", tag, n);
      end
   endtask

   task automatic test_reset();
      logic [15:0] d;
      rst = 1'b0;
      bus_if.cs = 1'b0; bus_if.rd = 1'b0; bus_if.wr = 1'b0;
      bus_if.addr = 4'h0; bus_if.d_in = 16'h0000;
      repeat (3) @(negedge clk);
      vectors++; if (sck !== 1'b0) begin miscompares++; $display("FAIL reset_sck: got %b want 0", sck); end
      vectors++; if (ss !== 1'b1) begin miscompares++; $display("FAIL reset_ss: got %b want 1", ss); end
      vectors++; if (mosi !== 1'b0) begin miscompares++; $display("FAIL reset_mosi: got %b want 0", mosi); end
      vectors++; if (bus_if.d_out !== 16'h0000) begin miscompares++; $display("FAIL reset_dout: got %h want 0000", bus_if.d_out); end
      rst = 1'b1;
      bus_read(ADDR_STATUS, d);
      vectors++; if (d !== 16'h0000) begin miscompares++; $display("FAIL reset_status: got %h want 0000", d); end
      bus_read(ADDR_RX, d);
      vectors++; if (d !== 16'h0000) begin miscompares++; $display("FAIL reset_rx: got %h want 0000", d); end
   endtask

   task automatic test_basic_frame();
      logic [15:0] d;
      int base;
      miso_pat = 8'h00;
      base = frames_done;
      launch(8'hB9);
      bus_read(ADDR_TX, d);
      vectors++; if (d !== 16'h00B9) begin miscompares++; $display("FAIL basic_txreg: got %h want 00B9", d); end
      repeat (8) @(negedge clk);
      bus_read(ADDR_STATUS, d);
      vectors++; if (d !== 16'h0002) begin miscompares++; $display("FAIL basic_busy: got %h want 0002", d); end
      wait_frame(base, "basic");
      vectors++; if (last_frame_len !== 64) begin miscompares++; $display("FAIL basic_len: got %0d want 64", last_frame_len); end
      vectors++; if (rise_cnt !== 8) begin miscompares++; $display("FAIL basic_rises: got %0d want 8", rise_cnt); end
      vectors++; if (mosi_cap !== 8'hB9) begin miscompares++; $display("FAIL basic_mosi: got %h want b9", mosi_cap); end
      vectors++; if (mosi !== 1'b1) begin miscompares++; $display("FAIL basic_mosi_hold: got %b want 1", mosi); end
      bus_read(ADDR_STATUS, d);
      vectors++; if (d !== 16'h0001) begin miscompares++; $display("FAIL basic_done: got %h want 0001", d); end
      bus_read(ADDR_STATUS, d);
      vectors++; if (d !== 16'h0001) begin miscompares++; $display("FAIL basic_done_sticky: got %h want 0001", d); end
   endtask

   task automatic test_receive();
      logic [15:0] d;
      int base;
      miso_pat = 8'hCC;
      base = frames_done;
      launch(8'h5A);
      wait_frame(base, "rx");
      vectors++; if (mosi_cap !== 8'h5A) begin miscompares++; $display("FAIL rx_mosi: got %h want 5a", mosi_cap); end
      bus_read(ADDR_RX, d);
      vectors++; if (d !== 16'h00CC) begin miscompares++; $display("FAIL rx_data: got %h want 00CC", d); end
      vectors++; if (mosi !== 1'b0) begin miscompares++; $display("FAIL rx_mosi_hold: got %b want 0", mosi); end
   endtask

   task automatic test_soft_reset();
      logic [15:0] d;
      int base;
      miso_pat = 8'h00;
      launch(8'hB9);
      repeat (20) @(negedge clk);
      bus_write(ADDR_SRST, 16'h0001);
      vectors++; if (ss !== 1'b1) begin miscompares++; $display("FAIL srst_ss: got %b want 1", ss); end
      vectors++; if (sck !== 1'b0) begin miscompares++; $display("FAIL srst_sck: got %b want 0", sck); end
      bus_read(ADDR_STATUS, d);
      vectors++; if (d !== 16'h0000) begin miscompares++; $display("FAIL srst_status: got %h want 0000", d); end
      bus_read(ADDR_RX, d);
      vectors++; if (d !== 16'h00CC) begin miscompares++; $display("FAIL srst_rx_kept: got %h want 00CC", d); end
      bus_read(ADDR_TX, d);
      vectors++; if (d !== 16'h00B9) begin miscompares++; $display("FAIL srst_tx_kept: got %h want 00B9", d); end
      bus_write(ADDR_SRST, 16'h0000);
      miso_pat = 8'h96;
      base = frames_done;
      launch(8'hB9);
      wait_frame(base, "srst_relaunch");
      vectors++; if (last_frame_len !== 64) begin miscompares++; $display("FAIL srst_len: got %0d want 64", last_frame_len); end
      vectors++; if (mosi_cap !== 8'hB9) begin miscompares++; $display("FAIL srst_mosi: got %h want b9", mosi_cap); end
      bus_read(ADDR_RX, d);
      vectors++; if (d !== 16'h0096) begin miscompares++; $display("FAIL srst_rx_new: got %h want 0096", d); end
      bus_read(ADDR_STATUS, d);
      vectors++; if (d !== 16'h0001) begin miscompares++; $display("FAIL srst_done: got %h want 0001", d); end
   endtask

   task automatic test_start_while_busy();
      logic [15:0] d;
      int base;
      miso_pat = 8'h00;
      base = frames_done;
      launch(8'h3C);
      repeat (20) @(negedge clk);
      bus_write(ADDR_TX, 16'h00FF);
      bus_write(ADDR_START, 16'h0001);
      bus_write(ADDR_START, 16'h0000);
      wait_frame(base, "busy");
      vectors++; if (last_frame_len !== 64) begin miscompares++; $display("FAIL busy_len: got %0d want 64", last_frame_len); end
      vectors++; if (mosi_cap !== 8'h3C) begin miscompares++; $display("FAIL busy_mosi: got %h want 3c", mosi_cap); end
      repeat (100) @(negedge clk);
      vectors++; if (frames_done !== base + 1) begin miscompares++; $display("FAIL busy_frames: got %0d want %0d", frames_done, base + 1); end
      vectors++; if (ss !== 1'b1) begin miscompares++; $display("FAIL busy_ss_idle: got %b want 1", ss); end
      bus_read(ADDR_STATUS, d);
      vectors++; if (d !== 16'h0001) begin miscompares++; $display("FAIL busy_status: got %h want 0001", d); end
   endtask

   task automatic test_bus_gating();
      logic [15:0] d;
      @(negedge clk);
      bus_if.cs = 1'b0; bus_if.wr = 1'b1; bus_if.addr = ADDR_TX; bus_if.d_in = 16'h0077;
      @(negedge clk);
      bus_if.wr = 1'b0;
      bus_read(ADDR_TX, d);
      vectors++; if (d !== 16'h00FF) begin miscompares++; $display("FAIL gate_wr: got %h want 00FF", d); end
      @(negedge clk);
      bus_if.cs = 1'b0; bus_if.rd = 1'b1; bus_if.addr = ADDR_TX;
      #1;
      vectors++; if (bus_if.d_out !== 16'h0000) begin miscompares++; $display("FAIL gate_rd: got %h want 0000", bus_if.d_out); end
      bus_if.rd = 1'b0;
      bus_read(4'hE, d);
      vectors++; if (d !== 16'h0000) begin miscompares++; $display("FAIL gate_unused: got %h want 0000", d); end
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      test_reset();
      test_basic_frame();
      test_receive();
      test_soft_reset();
      test_start_while_busy();
      test_bus_gating();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
